// File: rtl/sprite_cmd_sequencer.sv
// Sprite command bus transmitter: walks a host-loaded object table on every frame_start,
// emits PAT/X/Y update words into the back buffer, then one buffer-switch word.
module sprite_cmd_sequencer #(
   parameter int NUM_OBJ = 8,
   parameter int IDX_W   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tbl_we,
   input  logic [IDX_W-1:0] tbl_addr,
   input  logic [38:0]      tbl_wdata,
   input  logic             frame_start,
   output logic [31:0]      writedata,
   output logic             busy,
   output logic             frame_done,
   output logic [7:0]       overrun_cnt,
   output logic [2:0]       fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PAT, S_X, S_Y, S_NEXT, S_SWITCH, S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

   state_t           state, state_next;
   logic [IDX_W-1:0] idx, idx_next;
   logic [31:0]      word;
   logic [37:0]      ent;
   logic             back_buf;
   logic             addr_ok;

   // Enable bits are reset so an unloaded table scans as empty; payload needs no reset.
   logic [NUM_OBJ-1:0] tbl_en;
   logic [37:0]        tbl_data [NUM_OBJ];

   // Bus words are single-cycle broadcasts with no handshake: receivers decode every
   // cycle, a non-zero word is valid for exactly that cycle, and 32'h0 means NOP.
   logic [5:0]  ent_id;
   logic [4:0]  ent_child;
   logic        ent_vis, ent_flip;
   logic [4:0]  ent_pat;
   logic [9:0]  ent_x, ent_y;

   assign ent_id    = ent[37:32];
   assign ent_child = ent[31:27];
   assign ent_vis   = ent[26];
   assign ent_flip  = ent[25];
   assign ent_pat   = ent[24:20];
   assign ent_x     = ent[19:10];
   assign ent_y     = ent[9:0];

   assign addr_ok   = (int'(tbl_addr) < NUM_OBJ);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (tbl_we && addr_ok) tbl_data[tbl_addr] <= tbl_wdata[37:0];
   end

   always_comb begin
      state_next = state;
      idx_next   = idx;
      word       = 32'h0;
      case (state)
         S_IDLE:   if (frame_start) state_next = S_LOAD;
         S_LOAD:   state_next = tbl_en[idx] ? S_PAT : S_NEXT;
         S_PAT: begin
            word       = {ent_id, ent_child, 4'h1, 3'b001, back_buf,
                          ent_vis, ent_flip, 6'b0, ent_pat};
            state_next = S_X;
         end
         S_X: begin
            word       = {ent_id, ent_child, 4'h1, 3'b010, back_buf, 3'b0, ent_x};
            state_next = S_Y;
         end
         S_Y: begin
            word       = {ent_id, ent_child, 4'h1, 3'b011, back_buf, 3'b0, ent_y};
            state_next = S_NEXT;
         end
         S_NEXT: begin
            if (idx == LAST_IDX) begin
               state_next = S_SWITCH;
            end else begin
               idx_next   = idx + 1'b1;
               state_next = S_LOAD;
            end
         end
         S_SWITCH: begin
            word       = {6'b0, 5'b0, 4'hF, 3'b000, back_buf, 13'b0};
            state_next = S_DONE;
         end
         S_DONE: begin
            idx_next   = '0;
            state_next = S_IDLE;
         end
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         ent         <= '0;
         writedata   <= 32'h0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         overrun_cnt <= 8'h0;
         back_buf    <= 1'b1;
         tbl_en      <= '0;
      end else begin
         state      <= state_next;
         idx        <= idx_next;
         writedata  <= word;
         frame_done <= (state == S_DONE);
         // Entry is captured before any same-cycle write lands: read-before-write.
         if (state == S_LOAD) ent <= tbl_data[idx];
         if (state == S_IDLE && frame_start) busy <= 1'b1;
         else if (state == S_DONE)           busy <= 1'b0;
         if (frame_start && state != S_IDLE && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'h1;
         if (state == S_SWITCH) back_buf <= ~back_buf;
         if (tbl_we && addr_ok) tbl_en[tbl_addr] <= tbl_wdata[38];
      end
   end

endmodule
